// File: rtl/mreg_pkg.sv
// Shared encodings for the micro-register bank: sequencer phases, bus map codes, FSM states.
package mreg_pkg;

  localparam int CPU_STATES  = 8;
  localparam int CPU_STATE_W = $clog2(CPU_STATES);
  typedef logic [CPU_STATE_W-1:0] cpu_state_t;

  // Sequencer phases; only the two execute phases touch the bank.
  localparam cpu_state_t EXECUTE1 = cpu_state_t'(3);
  localparam cpu_state_t EXECUTE2 = cpu_state_t'(4);

  // reg_dst codes that stage bank registers from the shared write bus.
  localparam int REG_SEL_MAP     = 1;
  localparam int REG_WR_DATA_MAP = 2;
  localparam int REG_CTRL_MAP    = 3;

  localparam logic REG_FILE_READ  = 1'b0;
  localparam logic REG_FILE_WRITE = 1'b1;

  typedef enum logic {CLEAR, IDLE} mreg_state_e;

  // Next index for block transfers; wraps at depth-1 so non-power-of-two banks stay in range.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mreg_bank_if.sv
// Sequencer-side bus of the micro-register bank: control, shared write bus, read return and status.
interface mreg_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DST_WIDTH  = 4
);
  import mreg_pkg::*;

  cpu_state_t            cpu_state;
  logic                  reg_file_en;
  logic                  reg_file_rw;
  logic [DST_WIDTH-1:0]  reg_dst;
  logic [DATA_WIDTH-1:0] shared_write_bus;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  rd_valid;
  logic                  addr_err;
  logic                  busy;

  modport master (
    output cpu_state, reg_file_en, reg_file_rw, reg_dst, shared_write_bus,
    input  reg_rd_data, rd_valid, addr_err, busy
  );

  modport slave (
    input  cpu_state, reg_file_en, reg_file_rw, reg_dst, shared_write_bus,
    output reg_rd_data, rd_valid, addr_err, busy
  );

endinterface

// File: rtl/mreg_storage.sv
// Synchronous 1W/1R array with a registered read port; only the read register is reset.
module mreg_storage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; contents are zeroed by the owner's clear sequence, not by reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; holds its value between reads.
  always_ff @(posedge sys_clk) begin
    if (sys_reset)  rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mreg_bank.sv
// Micro-register bank: EXECUTE1 stages select/data/control from the shared bus,
// EXECUTE2 performs the array access. A post-reset sweep zeroes every entry.
module mreg_bank
  import mreg_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int DST_WIDTH  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  mreg_bank_if.slave  bus
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Range compare is done at least 9 bits wide so DEPTH=256 never truncates.
  localparam int CMP_W = (DATA_WIDTH > 9) ? DATA_WIDTH : 9;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  mreg_state_e           state_q, state_n;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_n;
  logic                  busy_q, busy_n;

  logic [ADDR_WIDTH-1:0] sel;
  logic                  sel_oor;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  auto_inc;
  logic                  rd_valid_q, addr_err_q;

  logic                  clearing, e1_go, e2_go, acc_ok, do_rd, do_wr;
  logic [ADDR_WIDTH-1:0] sel_inc;
  logic [ADDR_WIDTH-1:0] st_wr_addr;
  logic [DATA_WIDTH-1:0] st_wr_data, st_rd_data;

  assign clearing = (state_q == CLEAR);
  assign e1_go    = !clearing && bus.reg_file_en && (bus.cpu_state == EXECUTE1);
  assign e2_go    = !clearing && bus.reg_file_en && (bus.cpu_state == EXECUTE2);
  assign acc_ok   = e2_go && !sel_oor;
  assign do_rd    = acc_ok && (bus.reg_file_rw == REG_FILE_READ);
  assign do_wr    = acc_ok && (bus.reg_file_rw == REG_FILE_WRITE);
  assign sel_inc  = ADDR_WIDTH'(wrap_inc(32'(sel), DEPTH));

  // FSM state register; reset restarts the clear sweep from entry 0.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_n;
      clr_ptr_q <= clr_ptr_n;
      busy_q    <= busy_n;
    end
  end

  // Next state: sweep one entry per cycle, drop busy once the last entry is written.
  always_comb begin
    state_n   = state_q;
    clr_ptr_n = clr_ptr_q;
    busy_n    = busy_q;
    case (state_q)
      CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          state_n   = IDLE;
          clr_ptr_n = '0;
          busy_n    = 1'b0;
        end else begin
          clr_ptr_n = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase
  end

  // Staging registers; select also advances after a successful access when auto-increment is on.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      sel      <= '0;
      sel_oor  <= 1'b0;
      wr_data  <= '0;
      auto_inc <= 1'b0;
    end else if (e1_go) begin
      if (bus.reg_dst == DST_WIDTH'(REG_SEL_MAP)) begin
        sel     <= bus.shared_write_bus[ADDR_WIDTH-1:0];
        sel_oor <= (CMP_W'(bus.shared_write_bus) >= CMP_W'(DEPTH));
      end else if (bus.reg_dst == DST_WIDTH'(REG_WR_DATA_MAP)) begin
        wr_data <= bus.shared_write_bus;
      end else if (bus.reg_dst == DST_WIDTH'(REG_CTRL_MAP)) begin
        auto_inc <= bus.shared_write_bus[0];
      end
    end else if (acc_ok && auto_inc) begin
      sel <= sel_inc;
    end
  end

  // One-cycle status strobes, aligned with the registered read data.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd;
      addr_err_q <= e2_go && sel_oor;
    end
  end

  // Single write port shared by the clear sweep and EXECUTE2 writes.
  assign st_wr_addr = clearing ? clr_ptr_q : sel;
  assign st_wr_data = clearing ? '0 : wr_data;

  mreg_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .wr_en     (clearing || do_wr),
    .wr_addr   (st_wr_addr),
    .wr_data   (st_wr_data),
    .rd_en     (do_rd),
    .rd_addr   (sel),
    .rd_data   (st_rd_data)
  );

  assign bus.reg_rd_data = st_rd_data;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mreg_bank.sv
// Scoreboard bench: two banks (DEPTH 16 and 10) driven in lock-step against a behavioural model.
module tb_mreg_bank;
  import mreg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mreg_bank_if #(.DATA_WIDTH(16), .DST_WIDTH(4)) if0 ();
  mreg_bank_if #(.DATA_WIDTH(16), .DST_WIDTH(4)) if1 ();

  mreg_bank #(.DATA_WIDTH(16), .DEPTH(16), .DST_WIDTH(4)) dut0 (.sys_clk(clk), .sys_reset(rst), .bus(if0));
  mreg_bank #(.DATA_WIDTH(16), .DEPTH(10), .DST_WIDTH(4)) dut1 (.sys_clk(clk), .sys_reset(rst), .bus(if1));

  typedef struct { bit is_err; int data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int  checks = 0;
  int  errors = 0;
  bit  armed  = 0;

  // Behavioural model state, one slot per bank.
  int  depth [2] = '{16, 10};
  int  mem   [2][256];
  int  sel   [2];
  bit  oor   [2];
  int  wr    [2];
  bit  ainc  [2];
  int  rdv   [2];
  int  clr   [2];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  task automatic push(input int k, input bit e, input int d);
    exp_t x;
    x.is_err = e;
    x.data   = d;
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic m_reset(input int k);
    for (int i = 0; i < 256; i++) mem[k][i] = 0;
    sel[k] = 0; oor[k] = 0; wr[k] = 0; ainc[k] = 0; rdv[k] = 0;
    clr[k] = depth[k];
  endtask

  task automatic m_op(input int k, input bit en, input int st, input bit rw, input int dst, input int b);
    if (clr[k] > 0) begin
      clr[k]--;
      return;
    end
    if (!en) return;
    if (st == int'(EXECUTE1)) begin
      if (dst == REG_SEL_MAP) begin
        sel[k] = b;
        oor[k] = (b >= depth[k]);
      end else if (dst == REG_WR_DATA_MAP) begin
        wr[k] = b;
      end else if (dst == REG_CTRL_MAP) begin
        ainc[k] = b[0];
      end
    end else if (st == int'(EXECUTE2)) begin
      if (oor[k]) begin
        push(k, 1'b1, rdv[k]);
      end else begin
        if (rw == REG_FILE_READ) begin
          rdv[k] = mem[k][sel[k]];
          push(k, 1'b0, rdv[k]);
        end else begin
          mem[k][sel[k]] = wr[k];
        end
        if (ainc[k]) sel[k] = (sel[k] + 1) % depth[k];
      end
    end
  endtask

  // One bus cycle, applied just after a falling edge.
  task automatic cyc(input bit r, input bit en, input int st, input bit rw, input int dst, input int b);
    if (armed) begin
      check("busy", 0, 32'(if0.busy), 32'(clr[0] > 0));
      check("busy", 1, 32'(if1.busy), 32'(clr[1] > 0));
    end
    rst = r;
    if0.reg_file_en = en;  if1.reg_file_en = en;
    if0.cpu_state   = cpu_state_t'(st); if1.cpu_state = cpu_state_t'(st);
    if0.reg_file_rw = rw;  if1.reg_file_rw = rw;
    if0.reg_dst     = 4'(dst); if1.reg_dst = 4'(dst);
    if0.shared_write_bus = 16'(b); if1.shared_write_bus = 16'(b);
    if (r) begin
      m_reset(0); m_reset(1);
    end else begin
      m_op(0, en, st, rw, dst, b);
      m_op(1, en, st, rw, dst, b);
    end
    @(negedge clk);
    if (r) armed = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic e1(input int dst, input int b);
    cyc(1'b0, 1'b1, int'(EXECUTE1), 1'b0, dst, b);
  endtask

  task automatic e2(input bit rw);
    cyc(1'b0, 1'b1, int'(EXECUTE2), rw, 0, 0);
  endtask

  task automatic mon(input int k, input logic rv, input logic ae, input logic [15:0] d);
    exp_t e;
    bit   empty;
    if (rv !== 1'b0 || ae !== 1'b0) begin
      empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL strobe dut%0d unexpected rd_valid=%0b addr_err=%0b required none", k, rv, ae);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check("strobe_kind", k, 32'({rv, ae}), e.is_err ? 32'h1 : 32'h2);
        check("rd_data", k, 32'(d), 32'(e.data));
      end
    end
  endtask

  // Monitor: every strobe must match the oldest expected response.
  always @(negedge clk) begin
    if (armed) begin
      mon(0, if0.rd_valid, if0.addr_err, if0.reg_rd_data);
      mon(1, if1.rd_valid, if1.addr_err, if1.reg_rd_data);
    end
  end

  initial begin
    int st, dst, b;
    bit r, en, rw;
    if0.reg_file_en = 0; if1.reg_file_en = 0;
    if0.cpu_state = '0; if1.cpu_state = '0;
    if0.reg_file_rw = 0; if1.reg_file_rw = 0;
    if0.reg_dst = '0; if1.reg_dst = '0;
    if0.shared_write_bus = '0; if1.shared_write_bus = '0;
    @(negedge clk);

    // Reset, then sweep; read every index back.
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
    check("rst_rd_data", 0, 32'(if0.reg_rd_data), 0);
    check("rst_rd_valid", 0, 32'(if0.rd_valid), 0);
    check("rst_addr_err", 0, 32'(if0.addr_err), 0);
    check("rst_rd_data", 1, 32'(if1.reg_rd_data), 0);
    idle(16);
    for (int i = 0; i < 16; i++) begin
      e1(REG_SEL_MAP, i);
      e2(REG_FILE_READ);
    end

    // Write then read back.
    e1(REG_SEL_MAP, 3); e1(REG_WR_DATA_MAP, 16'hBEEF); e2(REG_FILE_WRITE);
    e1(REG_SEL_MAP, 3); e2(REG_FILE_READ);

    // Auto-increment block write with wrap, then read back.
    e1(REG_CTRL_MAP, 1); e1(REG_SEL_MAP, 14);
    for (int i = 0; i < 4; i++) begin
      e1(REG_WR_DATA_MAP, 16'hA0 + i);
      e2(REG_FILE_WRITE);
    end
    e1(REG_CTRL_MAP, 0);
    e1(REG_SEL_MAP, 14); e2(REG_FILE_READ);
    e1(REG_SEL_MAP, 15); e2(REG_FILE_READ);
    e1(REG_SEL_MAP, 0);  e2(REG_FILE_READ);
    e1(REG_SEL_MAP, 1);  e2(REG_FILE_READ);

    // Out-of-range select on the 10-deep bank, and wrap at its last entry.
    e1(REG_CTRL_MAP, 1); e1(REG_SEL_MAP, 12);
    e2(REG_FILE_READ); e2(REG_FILE_READ);
    e1(REG_SEL_MAP, 9); e2(REG_FILE_READ); e2(REG_FILE_READ);
    e1(REG_SEL_MAP, 16'hFF05); e2(REG_FILE_WRITE);
    e1(REG_CTRL_MAP, 0);

    // Reset in the 5th clear cycle; ops issued while busy are dropped.
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
    idle(4);
    cyc(1'b1, 1'b1, int'(EXECUTE2), REG_FILE_WRITE, 0, 0);
    for (int i = 0; i < 8; i++) begin
      e1(REG_SEL_MAP, i);
      e2(i[0] ? REG_FILE_WRITE : REG_FILE_READ);
    end
    e1(REG_SEL_MAP, 3); e2(REG_FILE_READ);

    // Bank not selected: nothing may change.
    e1(REG_SEL_MAP, 5); e1(REG_WR_DATA_MAP, 16'h1234); e2(REG_FILE_WRITE);
    cyc(1'b0, 1'b0, int'(EXECUTE1), 1'b0, REG_SEL_MAP, 7);
    cyc(1'b0, 1'b0, int'(EXECUTE1), 1'b0, REG_WR_DATA_MAP, 16'h5555);
    cyc(1'b0, 1'b0, int'(EXECUTE2), REG_FILE_WRITE, 0, 0);
    cyc(1'b0, 1'b0, int'(EXECUTE2), REG_FILE_READ, 0, 0);
    e2(REG_FILE_READ);
    e1(REG_SEL_MAP, 7); e2(REG_FILE_READ);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 249) == 0);
      en  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
          : (($urandom_range(0, 1) == 1) ? int'(EXECUTE1) : int'(EXECUTE2));
      rw  = 1'($urandom_range(0, 1));
      dst = int'($urandom_range(0, 4));
      b   = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 19)) : int'($urandom_range(0, 65535));
      cyc(r, en, st, rw, dst, b);
    end

    idle(3);
    check("pending", 0, 32'(q0.size()), 0);
    check("pending", 1, 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
